// File: rtl/sobel_window_ctrl.sv
// Sequencing controller for a 3x3 Sobel window: walks col/row over the frame and strobes the line buffers.
// Optional macro SOBEL_CTRL_ABORT_EN adds an abort input that drops an in-progress frame.
module sobel_window_ctrl #(
    parameter int PIC_WIDTH  = 480,
    parameter int PIC_HEIGHT = 272,
    parameter int CW         = 9,
    parameter int RW         = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
`ifdef SOBEL_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          pix_ready,
    output logic [CW-1:0] lb_addr,
    output logic          lb_wr_en,
    output logic          lb_rd_en,
    output logic          win_valid,
    output logic          win_full,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          busy,
    output logic          frame_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, win_valid_d;
    logic          win_full_q, win_full_d;
    logic          abort_req;
    logic          accept;
    logic          col_wrap;

    assign pix_ready = (state_q == FILL) || (state_q == RUN);

    // An abort wins over any pixel offered in the same cycle.
`ifdef SOBEL_CTRL_ABORT_EN
    assign abort_req = abort & pix_ready;
`else
    assign abort_req = 1'b0;
`endif

    assign accept   = pix_valid & pix_ready & ~abort_req;
    assign col_wrap = (col_q == COL_LAST);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = accept && (state_q == RUN);
        win_full_d  = win_valid_d && (col_q >= COL_TWO);
        case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL, RUN: begin
                if (abort_req) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (accept) begin
                    if (col_wrap) begin
                        col_d = '0;
                        row_d = row_q + ROW_ONE;
                        if (state_q == FILL && row_q == ROW_ONE) state_d = RUN;
                        // Last pixel of the frame: counters return to origin while DONE is shown.
                        if (state_q == RUN && row_q == ROW_LAST) begin
                            state_d = DONE;
                            row_d   = '0;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end
            default: begin
                state_d = IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_full_q  <= win_full_d;
        end
    end

    assign lb_addr    = col_q;
    assign lb_wr_en   = accept;
    assign lb_rd_en   = accept;
    assign win_valid  = win_valid_q;
    assign win_full   = win_full_q;
    assign col        = col_q;
    assign row        = row_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule
